// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, 1-cycle imem request, 2-entry output/skid queue.
// Optional perf counters enabled by defining FETCH_PERF_CNT_EN.
module fetch_stage #(
    parameter int                  bitwidth       = 32,
    parameter int                  IMEM_ADDR_BITS = 11,
    parameter logic [bitwidth-1:0] RESET_PC       = '0
) (
    input  logic                      clk,
    input  logic                      reset_n,
    output logic [IMEM_ADDR_BITS-1:0] imem_addr,
    output logic                      imem_rd_en,
    input  logic [bitwidth-1:0]       imem_rdata,
    input  logic                      id_ready,
    input  logic                      redirect_valid,
    input  logic [bitwidth-1:0]       redirect_pc,
    output logic                      id_valid,
    output logic [bitwidth-1:0]       id_inst,
    output logic [bitwidth-1:0]       id_pc,
    output logic [bitwidth-1:0]       id_pc_plus4,
    output logic [31:0]               perf_fetched,
    output logic [31:0]               perf_stall
);

    localparam logic [bitwidth-1:0] FOUR  = bitwidth'(4);
    localparam logic [bitwidth-1:0] ALIGN = ~bitwidth'(3);

    logic [bitwidth-1:0] pc;
    logic [bitwidth-1:0] inflight_pc;
    logic [bitwidth-1:0] fetch_addr;
    logic [bitwidth-1:0] skid_inst;
    logic [bitwidth-1:0] skid_pc;
    logic                inflight;
    logic                skid_valid;
    logic                drain;
    logic                issue;
    logic                ret;
    logic                out_free;
    logic [1:0]          occ;
    logic [1:0]          occ_left;

    assign fetch_addr = redirect_valid ? (redirect_pc & ALIGN) : pc;
    assign drain      = id_valid & id_ready;
    assign occ        = {1'b0, id_valid} + {1'b0, skid_valid}
                      + {1'b0, inflight};
    assign occ_left   = occ - {1'b0, drain};
    // Only issue when a slot is guaranteed for the returning word
    assign issue      = redirect_valid | (occ_left <= 2'd1);
    assign imem_rd_en = issue;
    assign imem_addr  = fetch_addr[IMEM_ADDR_BITS+1:2];
    assign ret        = inflight & ~redirect_valid;
    assign out_free   = ~id_valid | id_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc          <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else begin
            inflight <= issue;
            if (issue) begin
                pc          <= fetch_addr + FOUR;
                inflight_pc <= fetch_addr;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            id_valid    <= 1'b0;
            id_inst     <= '0;
            id_pc       <= '0;
            id_pc_plus4 <= FOUR;
            skid_valid  <= 1'b0;
            skid_inst   <= '0;
            skid_pc     <= '0;
        end else if (redirect_valid) begin
            id_valid   <= 1'b0;
            skid_valid <= 1'b0;
        end else if (out_free) begin
            if (skid_valid) begin
                // Skid holds the older word, so it goes out first
                id_valid    <= 1'b1;
                id_inst     <= skid_inst;
                id_pc       <= skid_pc;
                id_pc_plus4 <= skid_pc + FOUR;
                skid_valid  <= ret;
                if (ret) begin
                    skid_inst <= imem_rdata;
                    skid_pc   <= inflight_pc;
                end
            end else if (ret) begin
                id_valid    <= 1'b1;
                id_inst     <= imem_rdata;
                id_pc       <= inflight_pc;
                id_pc_plus4 <= inflight_pc + FOUR;
            end else begin
                id_valid <= 1'b0;
            end
        end else if (ret) begin
            skid_valid <= 1'b1;
            skid_inst  <= imem_rdata;
            skid_pc    <= inflight_pc;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_fetched <= '0;
            perf_stall   <= '0;
        end else begin
            if (drain)
                perf_fetched <= perf_fetched + 32'd1;
            if (id_valid && !id_ready)
                perf_stall <= perf_stall + 32'd1;
        end
    end
`else
    assign perf_fetched = 32'h0;
    assign perf_stall   = 32'h0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: program-order scoreboard plus
// directed latency, stall, redirect and async-reset checks.
module tb_fetch_stage;

    localparam int AW = 11;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [AW-1:0] imem_addr;
    logic          imem_rd_en;
    logic [31:0]   imem_rdata;
    logic          id_ready;
    logic          redirect_valid;
    logic [31:0]   redirect_pc;
    logic          id_valid;
    logic [31:0]   id_inst;
    logic [31:0]   id_pc;
    logic [31:0]   id_pc_plus4;
    logic [31:0]   perf_fetched;
    logic [31:0]   perf_stall;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] exp_q[$];
    logic [31:0] next_pc;
    int          m_drains;
    int          m_stalls;

    fetch_stage #(
        .bitwidth      (32),
        .IMEM_ADDR_BITS(AW),
        .RESET_PC      (32'h0)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .imem_addr     (imem_addr),
        .imem_rd_en    (imem_rd_en),
        .imem_rdata    (imem_rdata),
        .id_ready      (id_ready),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .id_valid      (id_valid),
        .id_inst       (id_inst),
        .id_pc         (id_pc),
        .id_pc_plus4   (id_pc_plus4),
        .perf_fetched  (perf_fetched),
        .perf_stall    (perf_stall)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word(input logic [31:0] byte_addr);
        logic [31:0] idx;
        idx = {21'd0, byte_addr[AW+1:2]};
        return 32'hC712_4000 + idx;
    endfunction

    // Behavioural synchronous ROM
    always @(posedge clk)
        if (imem_rd_en)
            imem_rdata <= 32'hC712_4000 + {21'd0, imem_addr};

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Scoreboard: expected PCs in program order, popped on each drain
    always @(negedge clk) begin
        if (!reset_n) begin
            exp_q.delete();
            next_pc  = 32'h0;
            m_drains = 0;
            m_stalls = 0;
        end else begin
            if (id_valid && !id_ready)
                m_stalls++;
            if (id_valid && id_ready) begin
                m_drains++;
                if (exp_q.size() == 0) begin
                    chk("sb_underflow", 32'd1, 32'd0);
                end else begin
                    logic [31:0] p;
                    p = exp_q.pop_front();
                    chk("sb_pc", id_pc, p);
                    chk("sb_inst", id_inst, word(p));
                    chk("sb_pc4", id_pc_plus4, p + 32'd4);
                end
            end
            if (redirect_valid) begin
                exp_q.delete();
                next_pc = redirect_pc & 32'hFFFF_FFFC;
            end
            while (exp_q.size() < 4) begin
                exp_q.push_back(next_pc);
                next_pc = next_pc + 32'd4;
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic startup_check();
        chk("start_v0", {31'd0, id_valid}, 32'd0);
        chk("start_addr", {21'd0, imem_addr}, 32'd0);
        chk("start_rden", {31'd0, imem_rd_en}, 32'd1);
        tick();
        chk("start_v1", {31'd0, id_valid}, 32'd0);
        tick();
        chk("start_v2", {31'd0, id_valid}, 32'd1);
        chk("start_inst", id_inst, 32'hC712_4000);
        chk("start_pc", id_pc, 32'h0);
        chk("start_pc4", id_pc_plus4, 32'h4);
        tick();
        chk("start_inst1", id_inst, 32'hC712_4001);
        chk("start_pc1", id_pc, 32'h4);
    endtask

    initial begin
        reset_n        = 1'b0;
        id_ready       = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        tick(3);
        chk("rst_valid", {31'd0, id_valid}, 32'd0);
        chk("rst_pc4", id_pc_plus4, 32'h4);
        chk("rst_pc", id_pc, 32'h0);
        reset_n = 1'b1;
        startup_check();

        // Stall at word[3]
        tick(2);
        chk("pre_stall", id_inst, word(32'hC));
        id_ready = 1'b0;
        #1;
        chk("stall_rden0", {31'd0, imem_rd_en}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("stall_hold", id_inst, word(32'hC));
            chk("stall_rden", {31'd0, imem_rd_en}, 32'd0);
        end
        tick();
        id_ready = 1'b1;
        tick();
        chk("rel_w4", id_inst, word(32'h10));
        tick();
        chk("rel_w5", id_inst, word(32'h14));
        tick(2);
        chk("pre_redir", id_inst, word(32'h1C));

        // Redirect with unaligned target
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0103;
        #1;
        chk("redir_addr", {21'd0, imem_addr}, 32'h40);
        chk("redir_rden", {31'd0, imem_rd_en}, 32'd1);
        tick();
        redirect_valid = 1'b0;
        chk("redir_v0", {31'd0, id_valid}, 32'd0);
        tick();
        chk("redir_v1", {31'd0, id_valid}, 32'd1);
        chk("redir_inst", id_inst, word(32'h100));
        chk("redir_pc", id_pc, 32'h100);
        tick(3);

        // Redirect during stall with skid full
        id_ready = 1'b0;
        tick(2);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0200;
        tick();
        redirect_valid = 1'b0;
        chk("rs_v0", {31'd0, id_valid}, 32'd0);
        tick();
        chk("rs_v1", {31'd0, id_valid}, 32'd1);
        chk("rs_pc", id_pc, 32'h200);
        chk("rs_inst", id_inst, word(32'h200));
        tick(2);
        chk("rs_hold", id_pc, 32'h200);
        id_ready = 1'b1;
        tick(3);

        // PC wrap at the top of the address space
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        tick();
        chk("wrap_pc", id_pc, 32'hFFFF_FFFC);
        chk("wrap_pc4", id_pc_plus4, 32'h0);
        chk("wrap_inst", id_inst, word(32'hFFFF_FFFC));
        tick();
        chk("wrap_next", id_pc, 32'h0);
        tick(4);

        // Random ready pattern through the scoreboard
        for (int i = 0; i < 40; i++) begin
            id_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        id_ready = 1'b1;
        tick(2);

        // Async reset between edges
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        chk("arst_valid", {31'd0, id_valid}, 32'd0);
        chk("arst_addr", {21'd0, imem_addr}, 32'd0);
        chk("arst_pc4", id_pc_plus4, 32'h4);
        tick(2);
        reset_n = 1'b1;
        startup_check();

        // Perf counters: drains and stalls since last reset
        tick(7);
        id_ready = 1'b0;
        tick(5);
        id_ready = 1'b1;
        tick(2);
        @(negedge clk);
        #1;
`ifdef FETCH_PERF_CNT_EN
        chk("perf_fetched", perf_fetched, m_drains);
        chk("perf_stall", perf_stall, m_stalls);
`else
        chk("perf_fetched", perf_fetched, 32'h0);
        chk("perf_stall", perf_stall, 32'h0);
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
